// File: rtl/microcode_pkg.sv
// Shared definitions for the microcode sequencer slice.
//
// Contents:
//   MC_WIDTH / MC_NUM_STAGES / MC_ROM_DEPTH / MC_UPC_WIDTH - default geometry
//   rom_entry_t  - micro-ROM entry layout {last, next_upc, mc}
//   seq_state_t  - sequencer FSM states {IDLE, FETCH, ISSUE}
//   stage_word() - pull stage k's microcode word out of the flattened stage_mc bus
//   make_entry() - build a ROM entry from its fields
package microcode_pkg;

  localparam int MC_WIDTH      = 25;
  localparam int MC_NUM_STAGES = 4;
  localparam int MC_ROM_DEPTH  = 64;
  localparam int MC_UPC_WIDTH  = $clog2(MC_ROM_DEPTH);

  typedef struct packed {
    logic                    last;
    logic [MC_UPC_WIDTH-1:0] next_upc;
    logic [MC_WIDTH-1:0]     mc;
  } rom_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE
  } seq_state_t;

  // Stage k's word sits at bits [k*MC_WIDTH +: MC_WIDTH] of the flattened bus.
  function automatic logic [MC_WIDTH-1:0] stage_word(
    input logic [MC_NUM_STAGES*MC_WIDTH-1:0] bus,
    input int                                k
  );
    return bus[k*MC_WIDTH +: MC_WIDTH];
  endfunction

  function automatic rom_entry_t make_entry(
    input logic                    last,
    input logic [MC_UPC_WIDTH-1:0] next_upc,
    input logic [MC_WIDTH-1:0]     mc
  );
    rom_entry_t e;
    e.last     = last;
    e.next_upc = next_upc;
    e.mc       = mc;
    return e;
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// Writable micro-ROM with synchronous read.
//
// The read address is registered on the clock edge when re=1 and the array
// is read from that register, so data for an address presented at edge T is
// visible after T. The address register is the sequencer's micro-PC (reset
// to 0); it only moves on re, so the output word stays put while the
// sequencer is held. Array contents are not reset.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (address register only)
//   we        - write strobe, takes effect at the edge
//   waddr     - write address
//   wdata     - write data {last, next_upc, mc}
//   re        - load raddr into the micro-PC
//   raddr     - read address
//   rdata     - entry at the current micro-PC
module microcode_rom
  import microcode_pkg::*;
#(
  parameter int DATA_W = MC_WIDTH + MC_UPC_WIDTH + 1,
  parameter int DEPTH  = MC_ROM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] upc;

  // Single write port; the array itself carries no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read address doubles as the micro-PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     upc <= '0;
    else if (re) upc <= raddr;
  end

  assign rdata = mem[upc];

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: walks micro-programs out of a writable micro-ROM and
// carries each issued word down a NUM_STAGES pipeline with per-stage valid,
// stall back-pressure, bubble insertion and flush.
//
// Build option: MICROCODE_BUBBLE_ZERO_EN - when defined, every stage whose
// valid is 0 drives an all-zero stage_mc slice; otherwise an invalid stage
// keeps its stale word and consumers must qualify with stage_valid.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   in_valid     - decoder presents an entry address
//   in_ready     - entry accepted this cycle
//   in_entry     - first micro-PC of the program
//   rom_we       - ROM write strobe (dropped while busy)
//   rom_addr     - ROM write address
//   rom_wdata    - ROM entry {last, next_upc, mc}
//   rom_wr_err   - one-cycle pulse: a write was dropped because busy
//   stall        - per-stage hold request
//   flush        - per-stage kill request (flush[k] kills stages 0..k)
//   stage_valid  - stage k holds a live word
//   stage_mc     - stage k word at bits [k*WIDTH +: WIDTH]
//   busy         - sequencer not IDLE or any stage valid
module microcode_sequencer
  import microcode_pkg::*;
#(
  parameter int WIDTH      = 25,
  parameter int NUM_STAGES = 4,
  parameter int ROM_DEPTH  = 64,
  parameter int UPC_WIDTH  = $clog2(ROM_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [UPC_WIDTH-1:0]          in_entry,
  input  logic                          rom_we,
  input  logic [UPC_WIDTH-1:0]          rom_addr,
  input  logic [WIDTH+UPC_WIDTH:0]      rom_wdata,
  output logic                          rom_wr_err,
  input  logic [NUM_STAGES-1:0]         stall,
  input  logic [NUM_STAGES-1:0]         flush,
  output logic [NUM_STAGES-1:0]         stage_valid,
  output logic [NUM_STAGES*WIDTH-1:0]   stage_mc,
  output logic                          busy
);

  localparam int ENTRY_W = WIDTH + UPC_WIDTH + 1;

  seq_state_t state, state_nxt;

  logic [ENTRY_W-1:0]   rom_rdata;
  logic                 rom_re;
  logic [UPC_WIDTH-1:0] rom_raddr;
  logic                 cur_last;
  logic [UPC_WIDTH-1:0] cur_next;
  logic [WIDTH-1:0]     cur_mc;

  logic                 any_flush;
  logic                 issue;
  logic                 accept;

  logic [NUM_STAGES-1:0]            hold, kill, valid_q, valid_in;
  logic [NUM_STAGES-1:0][WIDTH-1:0] mc_q, mc_in;

  microcode_rom #(
    .DATA_W (ENTRY_W),
    .DEPTH  (ROM_DEPTH),
    .ADDR_W (UPC_WIDTH)
  ) u_rom (
    .clk   (clk),
    .rst   (rst),
    .we    (rom_we & ~busy),
    .waddr (rom_addr),
    .wdata (rom_wdata),
    .re    (rom_re),
    .raddr (rom_raddr),
    .rdata (rom_rdata)
  );

  assign {cur_last, cur_next, cur_mc} = rom_rdata;
  assign any_flush = |flush;
  assign busy      = (state != IDLE) | (|valid_q);

  // A stall anywhere above stage k holds stage k; a flush anywhere at or
  // above stage k kills it.
  always_comb begin
    hold = '0;
    kill = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      hold[k] = |(stall >> k);
      kill[k] = |(flush >> k);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state. Any flush aborts to IDLE; issuing a last word either
  // chains straight into the next program or goes idle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = FETCH;
      FETCH, ISSUE: begin
        if (any_flush)  state_nxt = IDLE;
        else if (issue) state_nxt = cur_last ? (accept ? FETCH : IDLE) : ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs. In FETCH and ISSUE the ROM output already holds the word to
  // issue; it is only replaced when a new address is read.
  always_comb begin
    in_ready  = 1'b0;
    issue     = 1'b0;
    rom_re    = 1'b0;
    rom_raddr = in_entry;
    case (state)
      IDLE: in_ready = ~any_flush;
      FETCH, ISSUE: begin
        issue    = ~hold[0] & ~any_flush;
        in_ready = issue & cur_last;
        if (issue && !cur_last) begin
          rom_re    = 1'b1;
          rom_raddr = cur_next;
        end
      end
      default: ;
    endcase
    accept = in_ready & in_valid;
    if (accept) begin
      rom_re    = 1'b1;
      rom_raddr = in_entry;
    end
  end

  // What each stage would load if it advances: stage 0 takes the issued
  // word, stage k takes stage k-1 unless that stage is held (bubble).
  always_comb begin
    valid_in    = '0;
    mc_in       = '0;
    valid_in[0] = issue;
    mc_in[0]    = cur_mc;
    for (int k = 1; k < NUM_STAGES; k++) begin
      valid_in[k] = valid_q[k-1] & ~hold[k-1];
      mc_in[k]    = mc_q[k-1];
    end
  end

  // Pipeline registers: flush beats stall, held stages keep word and valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      mc_q    <= '0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (kill[k]) begin
          valid_q[k] <= 1'b0;
`ifdef MICROCODE_BUBBLE_ZERO_EN
          mc_q[k]    <= '0;
`endif
        end else if (!hold[k]) begin
          valid_q[k] <= valid_in[k];
`ifdef MICROCODE_BUBBLE_ZERO_EN
          mc_q[k]    <= valid_in[k] ? mc_in[k] : '0;
`else
          if (valid_in[k]) mc_q[k] <= mc_in[k];
`endif
        end
      end
    end
  end

  // Dropped-write indication, one cycle after the offending strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rom_wr_err <= 1'b0;
    else     rom_wr_err <= rom_we & busy;
  end

  assign stage_valid = valid_q;
  assign stage_mc    = mc_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: a table of per-cycle
// {inputs, expected outputs} records for the single-word, chained, stall and
// flush programs, followed by hand-written ROM-write and reset sequences.
module tb_microcode_sequencer;
  import microcode_pkg::*;

  localparam int W  = 25;
  localparam int NS = 4;
  localparam int UW = 6;

  localparam logic [W-1:0] Z    = '0;
  localparam logic [W-1:0] M5   = 25'h1ABCDE;
  localparam logic [W-1:0] M8   = 25'h0800008;
  localparam logic [W-1:0] M9   = 25'h0900009;
  localparam logic [W-1:0] M10  = 25'h0A0000A;
  localparam logic [W-1:0] M20  = 25'h1400014;
  localparam logic [W-1:0] M21  = 25'h1500015;
  localparam logic [W-1:0] M22  = 25'h1600016;
  localparam logic [W-1:0] M23  = 25'h1700017;
  localparam logic [W-1:0] M30A = 25'h0333333;
  localparam logic [W-1:0] M30B = 25'h0444444;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid, in_ready;
  logic [UW-1:0]   in_entry;
  logic            rom_we, rom_wr_err;
  logic [UW-1:0]   rom_addr;
  logic [W+UW:0]   rom_wdata;
  logic [NS-1:0]   stall, flush, stage_valid;
  logic [NS*W-1:0] stage_mc;
  logic            busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  microcode_sequencer #(
    .WIDTH(W), .NUM_STAGES(NS), .ROM_DEPTH(64), .UPC_WIDTH(UW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_entry(in_entry),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata), .rom_wr_err(rom_wr_err),
    .stall(stall), .flush(flush),
    .stage_valid(stage_valid), .stage_mc(stage_mc), .busy(busy)
  );

  typedef struct {
    logic                    iv;
    logic [UW-1:0]           entry;
    logic [NS-1:0]           stall;
    logic [NS-1:0]           flush;
    logic                    exp_ready;
    logic [NS-1:0]           exp_valid;
    logic [NS-1:0][W-1:0]    exp_mc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic [UW-1:0] e,
                              input logic [NS-1:0] st, input logic [NS-1:0] fl,
                              input logic rdy, input logic [NS-1:0] v,
                              input logic [W-1:0] m0, input logic [W-1:0] m1,
                              input logic [W-1:0] m2, input logic [W-1:0] m3);
    vec_t r;
    r.iv        = iv;
    r.entry     = e;
    r.stall     = st;
    r.flush     = fl;
    r.exp_ready = rdy;
    r.exp_valid = v;
    r.exp_mc[0] = m0;
    r.exp_mc[1] = m1;
    r.exp_mc[2] = m2;
    r.exp_mc[3] = m3;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    in_valid = v.iv;
    in_entry = v.entry;
    stall    = v.stall;
    flush    = v.flush;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    chk($sformatf("v%0d.in_ready", idx), 32'(in_ready), 32'(v.exp_ready));
    chk($sformatf("v%0d.stage_valid", idx), 32'(stage_valid), 32'(v.exp_valid));
    for (int k = 0; k < NS; k++) begin
      if (v.exp_valid[k])
        chk($sformatf("v%0d.mc%0d", idx, k), 32'(stage_word(stage_mc, k)), 32'(v.exp_mc[k]));
`ifdef MICROCODE_BUBBLE_ZERO_EN
      else
        chk($sformatf("v%0d.bubble_mc%0d", idx, k), 32'(stage_word(stage_mc, k)), 32'(Z));
`endif
    end
  endtask

  task automatic rom_write(input logic [UW-1:0] a, input logic last,
                           input logic [UW-1:0] nxt, input logic [W-1:0] mc);
    rom_we    = 1'b1;
    rom_addr  = a;
    rom_wdata = make_entry(last, nxt, mc);
    tick();
    rom_we    = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk({name, ".idle"}, 32'(busy), 32'd0);
  endtask

  // Start a program, check its first word reaches stage 0 two cycles later.
  task automatic run_prog(input logic [UW-1:0] e, input logic [W-1:0] exp, input string name);
    in_valid = 1'b1;
    in_entry = e;
    tick();
    in_valid = 1'b0;
    tick();
    chk({name, ".valid0"}, 32'(stage_valid[0]), 32'd1);
    chk({name, ".mc0"}, 32'(stage_word(stage_mc, 0)), 32'(exp));
    wait_idle(name);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    in_valid = 1'b0; in_entry = '0; rom_we = 1'b0; rom_addr = '0; rom_wdata = '0;
    stall = '0; flush = '0;

    #2;
    chk("reset.stage_valid", 32'(stage_valid), 32'd0);
    chk("reset.stage_mc_lo", stage_mc[31:0], 32'd0);
    chk("reset.stage_mc_hi", 32'(stage_mc[NS*W-1:32]), 32'd0);
    chk("reset.rom_wr_err", 32'(rom_wr_err), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.busy", 32'(busy), 32'd0);

    tick();
    tick();
    rst = 1'b0;
    tick();

    rom_write(6'd5,  1'b1, 6'd0,  M5);
    rom_write(6'd8,  1'b0, 6'd9,  M8);
    rom_write(6'd9,  1'b0, 6'd10, M9);
    rom_write(6'd10, 1'b1, 6'd0,  M10);
    rom_write(6'd20, 1'b0, 6'd21, M20);
    rom_write(6'd21, 1'b0, 6'd22, M21);
    rom_write(6'd22, 1'b0, 6'd23, M22);
    rom_write(6'd23, 1'b1, 6'd0,  M23);
    rom_write(6'd30, 1'b1, 6'd0,  M30A);

    // Single-word program at 5.
    vecs.push_back(mk(1'b1, 6'd5, 4'b0000, 4'b0000, 1'b1, 4'b0000, Z,   Z,   Z,   Z));
    vecs.push_back(mk(1'b0, 6'd0, 4'b0000, 4'b0000, 1'b1, 4'b0000, Z,   Z,   Z,   Z));
    vecs.push_back(mk(1'b0, 6'd0, 4'b0000, 4'b0000, 1'b1, 4'b0001, M5,  Z,   Z,   Z));
    vecs.push_back(mk(1'b0, 6'd0, 4'b0000, 4'b0000, 1'b1, 4'b0010, Z,   M5,  Z,   Z));
    vecs.push_back(mk(1'b0, 6'd0, 4'b0000, 4'b0000, 1'b1, 4'b0100, Z,   Z,   M5,  Z));
    vecs.push_back(mk(1'b0, 6'd0, 4'b0000, 4'b0000, 1'b1, 4'b1000, Z,   Z,   Z,   M5));
    vecs.push_back(mk(1'b0, 6'd0, 4'b0000, 4'b0000, 1'b1, 4'b0000, Z,   Z,   Z,   Z));
    // Chain 8->9->10, entry 5 offered while 10 issues.
    vecs.push_back(mk(1'b1, 6'd8, 4'b0000, 4'b0000, 1'b1, 4'b0000, Z,   Z,   Z,   Z));
    vecs.push_back(mk(1'b0, 6'd0, 4'b0000, 4'b0000, 1'b0, 4'b0000, Z,   Z,   Z,   Z));
    vecs.push_back(mk(1'b0, 6'd0, 4'b0000, 4'b0000, 1'b0, 4'b0001, M8,  Z,   Z,   Z));
    vecs.push_back(mk(1'b1, 6'd5, 4'b0000, 4'b0000, 1'b1, 4'b0011, M9,  M8,  Z,   Z));
    vecs.push_back(mk(1'b0, 6'd0, 4'b0000, 4'b0000, 1'b1, 4'b0111, M10, M9,  M8,  Z));
    vecs.push_back(mk(1'b0, 6'd0, 4'b0000, 4'b0000, 1'b1, 4'b1111, M5,  M10, M9,  M8));
    vecs.push_back(mk(1'b0, 6'd0, 4'b0000, 4'b0000, 1'b1, 4'b1110, Z,   M5,  M10, M9));
    vecs.push_back(mk(1'b0, 6'd0, 4'b0000, 4'b0000, 1'b1, 4'b1100, Z,   Z,   M5,  M10));
    vecs.push_back(mk(1'b0, 6'd0, 4'b0000, 4'b0000, 1'b1, 4'b1000, Z,   Z,   Z,   M5));
    vecs.push_back(mk(1'b0, 6'd0, 4'b0000, 4'b0000, 1'b1, 4'b0000, Z,   Z,   Z,   Z));
    // Four-word program at 20 with stall[2] for two cycles.
    vecs.push_back(mk(1'b1, 6'd20, 4'b0000, 4'b0000, 1'b1, 4'b0000, Z,   Z,   Z,   Z));
    vecs.push_back(mk(1'b0, 6'd0,  4'b0000, 4'b0000, 1'b0, 4'b0000, Z,   Z,   Z,   Z));
    vecs.push_back(mk(1'b0, 6'd0,  4'b0000, 4'b0000, 1'b0, 4'b0001, M20, Z,   Z,   Z));
    vecs.push_back(mk(1'b0, 6'd0,  4'b0000, 4'b0000, 1'b0, 4'b0011, M21, M20, Z,   Z));
    vecs.push_back(mk(1'b0, 6'd0,  4'b0100, 4'b0000, 1'b0, 4'b0111, M22, M21, M20, Z));
    vecs.push_back(mk(1'b0, 6'd0,  4'b0100, 4'b0000, 1'b0, 4'b0111, M22, M21, M20, Z));
    vecs.push_back(mk(1'b0, 6'd0,  4'b0000, 4'b0000, 1'b1, 4'b0111, M22, M21, M20, Z));
    vecs.push_back(mk(1'b0, 6'd0,  4'b0000, 4'b0000, 1'b1, 4'b1111, M23, M22, M21, M20));
    vecs.push_back(mk(1'b0, 6'd0,  4'b0000, 4'b0000, 1'b1, 4'b1110, Z,   M23, M22, M21));
    vecs.push_back(mk(1'b0, 6'd0,  4'b0000, 4'b0000, 1'b1, 4'b1100, Z,   Z,   M23, M22));
    vecs.push_back(mk(1'b0, 6'd0,  4'b0000, 4'b0000, 1'b1, 4'b1000, Z,   Z,   Z,   M23));
    vecs.push_back(mk(1'b0, 6'd0,  4'b0000, 4'b0000, 1'b1, 4'b0000, Z,   Z,   Z,   Z));
    // Same program, flush[1] with a competing in_valid that must be refused.
    vecs.push_back(mk(1'b1, 6'd20, 4'b0000, 4'b0000, 1'b1, 4'b0000, Z,   Z,   Z,   Z));
    vecs.push_back(mk(1'b0, 6'd0,  4'b0000, 4'b0000, 1'b0, 4'b0000, Z,   Z,   Z,   Z));
    vecs.push_back(mk(1'b0, 6'd0,  4'b0000, 4'b0000, 1'b0, 4'b0001, M20, Z,   Z,   Z));
    vecs.push_back(mk(1'b0, 6'd0,  4'b0000, 4'b0000, 1'b0, 4'b0011, M21, M20, Z,   Z));
    vecs.push_back(mk(1'b1, 6'd5,  4'b0000, 4'b0010, 1'b0, 4'b0111, M22, M21, M20, Z));
    vecs.push_back(mk(1'b0, 6'd0,  4'b0000, 4'b0000, 1'b1, 4'b1100, Z,   Z,   M21, M20));
    vecs.push_back(mk(1'b0, 6'd0,  4'b0000, 4'b0000, 1'b1, 4'b1000, Z,   Z,   Z,   M21));
    vecs.push_back(mk(1'b0, 6'd0,  4'b0000, 4'b0000, 1'b1, 4'b0000, Z,   Z,   Z,   Z));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], i);
      tick();
    end
    in_valid = 1'b0; stall = '0; flush = '0;

    // ROM write while busy is dropped; write while idle lands.
    in_valid = 1'b1;
    in_entry = 6'd30;
    tick();
    in_valid = 1'b0;
    chk("wrbusy.busy", 32'(busy), 32'd1);
    rom_we    = 1'b1;
    rom_addr  = 6'd30;
    rom_wdata = make_entry(1'b1, 6'd0, M30B);
    tick();
    rom_we = 1'b0;
    chk("wrbusy.err_pulse", 32'(rom_wr_err), 32'd1);
    tick();
    chk("wrbusy.err_clear", 32'(rom_wr_err), 32'd0);
    wait_idle("wrbusy");
    run_prog(6'd30, M30A, "readback_after_drop");
    rom_write(6'd30, 1'b1, 6'd0, M30B);
    chk("wridle.no_err", 32'(rom_wr_err), 32'd0);
    run_prog(6'd30, M30B, "readback_after_write");

    // Asynchronous reset in the middle of the 8->9->10 chain.
    in_valid = 1'b1;
    in_entry = 6'd8;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("midrst.pre_valid", 32'(stage_valid), 32'b0011);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.stage_valid", 32'(stage_valid), 32'd0);
    chk("midrst.stage_mc_lo", stage_mc[31:0], 32'd0);
    chk("midrst.stage_mc_hi", 32'(stage_mc[NS*W-1:32]), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    run_prog(6'd5, M5, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
